// File: rtl/md_pkg.sv
// md_pkg: op codes, FSM states and op-class helpers for the multiply/divide unit
package md_pkg;
  typedef enum logic [3:0] {
    MD_MULTU = 4'h0,
    MD_MULT  = 4'h1,
    MD_DIVU  = 4'h2,
    MD_DIV   = 4'h3,
    MD_MADDU = 4'h4,
    MD_MADD  = 4'h5,
    MD_MSUBU = 4'h6,
    MD_MSUB  = 4'h7,
    MD_MTHI  = 4'h8,
    MD_MTLO  = 4'h9
  } md_op_t;
  typedef enum logic {IDLE, RUN} md_state_t;
  function automatic logic md_is_arith(md_op_t op);
    return !op[3];
  endfunction
  function automatic logic md_is_signed(md_op_t op);
    return op[0];
  endfunction
  function automatic logic md_is_div(md_op_t op);
    return op inside {MD_DIVU, MD_DIV};
  endfunction
  function automatic logic md_is_acc(md_op_t op);
    return op inside {MD_MADDU, MD_MADD, MD_MSUBU, MD_MSUB};
  endfunction
  function automatic logic md_is_sub(md_op_t op);
    return op inside {MD_MSUBU, MD_MSUB};
  endfunction
endpackage

// File: rtl/md_if.sv
// md_if: decoder-side command/result bundle of the multiply/divide unit
interface md_if import md_pkg::*; #(parameter int WIDTH = 32) ();
  logic start;
  logic we;
  logic cancel;
  logic busy;
  md_op_t op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, a, b, we, cancel, input busy, hi, lo);
  modport slave (input start, op, a, b, we, cancel, output busy, hi, lo);
endinterface

// File: rtl/md_divider.sv
// md_divider: combinational signed/unsigned divide with defined divide-by-zero result
module md_divider #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sgn,
  output logic [WIDTH-1:0] quo,
  output logic [WIDTH-1:0] rem
);
  logic neg_a, neg_b, zero;
  logic [WIDTH-1:0] ua, ub, uq, ur;
  assign neg_a = sgn & a[WIDTH-1];
  assign neg_b = sgn & b[WIDTH-1];
  assign zero = b == '0;
  assign ua = neg_a ? -a : a;
  assign ub = neg_b ? -b : b;
  assign uq = zero ? '1 : ua / ub;
  assign ur = zero ? '0 : ua % ub;
  // min / -1 falls out of the magnitude path as quotient = min, remainder = 0
  assign quo = zero ? '1 : (neg_a ^ neg_b) ? -uq : uq;
  assign rem = zero ? a : neg_a ? -ur : ur;
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide/accumulate engine with HI/LO registers
module md_unit import md_pkg::*; #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic clk,
  input logic reset,
  md_if.slave bus
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  md_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] hi_q, lo_q, quo, rem;
  logic [2*WIDTH-1:0] pend, prod, acc, res;
  logic sgn, launch, commit, done;
  assign sgn = md_is_signed(bus.op);
  assign prod = {{WIDTH{sgn & bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{sgn & bus.b[WIDTH-1]}}, bus.b};
  assign acc = md_is_sub(bus.op) ? {hi_q, lo_q} - prod : {hi_q, lo_q} + prod;
  assign res = md_is_div(bus.op) ? {rem, quo} : md_is_acc(bus.op) ? acc : prod;
  assign done = cnt == CW'(1);
  md_divider #(.WIDTH(WIDTH)) u_div (.a(bus.a), .b(bus.b), .sgn(sgn), .quo(quo), .rem(rem));
  always_comb begin
    launch = state == IDLE && bus.start && !bus.cancel && !bus.we && md_is_arith(bus.op);
    commit = state == RUN && done && !bus.cancel;
    state_n = state == IDLE ? (launch ? RUN : IDLE) : (done || bus.cancel ? IDLE : RUN);
    cnt_n = state == IDLE ? (launch ? (md_is_div(bus.op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES)) : cnt)
                          : cnt - CW'(1);
  end
  // Result is computed at launch so later operand changes cannot affect it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      pend <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (launch) pend <= res;
      if (commit) {hi_q, lo_q} <= pend;
      else if (state == IDLE && bus.we) begin
        if (bus.op == MD_MTHI) hi_q <= bus.a;
        if (bus.op == MD_MTLO) lo_q <= bus.a;
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.hi = hi_q;
  assign bus.lo = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized and directed checks of md_unit against an arithmetic reference model
module tb_md_unit;
  import md_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] m_hilo;
  always #5 clk = ~clk;
  md_if #(.WIDTH(32)) b32 ();
  md_if #(.WIDTH(16)) b16 ();
  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (.clk(clk), .reset(reset), .bus(b32));
  md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut16 (.clk(clk), .reset(reset), .bus(b16));
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [63:0] model(md_op_t op, logic [31:0] a, logic [31:0] b, logic [63:0] hilo);
    longint sa, sb;
    int ia, ib;
    logic [63:0] up;
    sa = $signed(a);
    sb = $signed(b);
    ia = a;
    ib = b;
    up = {32'b0, a} * {32'b0, b};
    case (op)
      MD_MULTU: return up;
      MD_MULT:  return sa * sb;
      MD_MADDU: return hilo + up;
      MD_MADD:  return hilo + (sa * sb);
      MD_MSUBU: return hilo - up;
      MD_MSUB:  return hilo - (sa * sb);
      MD_DIVU:  return b == 0 ? {a, 32'hffffffff} : {a % b, a / b};
      MD_DIV: begin
        if (b == 0) return {a, 32'hffffffff};
        if (a == 32'h80000000 && b == 32'hffffffff) return {32'h0, a};
        return {32'(ia % ib), 32'(ia / ib)};
      end
      default: return hilo;
    endcase
  endfunction
  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hffffffff;
      2: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction
  task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int n;
    exp = model(op, a, b, m_hilo);
    n = md_is_div(op) ? 10 : 5;
    b32.start = 1'b1;
    b32.op = op;
    b32.a = a;
    b32.b = b;
    step;
    b32.start = 1'b0;
    b32.a = $urandom;
    b32.b = $urandom;
    for (int k = 1; k <= n; k++) begin
      check("busy_run", 64'(b32.busy), 64'd1);
      if (k < n) step;
    end
    check("hold_hilo", {b32.hi, b32.lo}, m_hilo);
    step;
    check("busy_done", 64'(b32.busy), 64'd0);
    check($sformatf("result_%s", op.name()), {b32.hi, b32.lo}, exp);
    m_hilo = exp;
  endtask
  task automatic mt(input md_op_t op, input logic [31:0] d);
    b32.we = 1'b1;
    b32.op = op;
    b32.a = d;
    step;
    b32.we = 1'b0;
    if (op == MD_MTHI) m_hilo[63:32] = d;
    else m_hilo[31:0] = d;
    check("mt_write", {b32.hi, b32.lo}, m_hilo);
  endtask
  initial begin
    logic [63:0] prior, exp;
    {b32.start, b32.we, b32.cancel, b32.a, b32.b} = '0;
    {b16.start, b16.we, b16.cancel, b16.a, b16.b} = '0;
    b32.op = MD_MULTU;
    b16.op = MD_MULTU;
    #2;
    check("reset_busy", 64'(b32.busy), 64'd0);
    check("reset_hilo", {b32.hi, b32.lo}, 64'd0);
    step;
    step;
    reset = 1'b0;
    m_hilo = '0;
    run_op(MD_MULT, 32'hffffffff, 32'h2);
    check("mult_const", {b32.hi, b32.lo}, 64'hffffffff_fffffffe);
    run_op(MD_MULTU, 32'hffffffff, 32'h2);
    check("multu_const", {b32.hi, b32.lo}, 64'h00000001_fffffffe);
    run_op(MD_DIV, 32'hfffffff9, 32'h2);
    check("div_const", {b32.hi, b32.lo}, 64'hffffffff_fffffffd);
    run_op(MD_DIVU, 32'h1234, 32'h0);
    check("divu_zero_const", {b32.hi, b32.lo}, 64'h00001234_ffffffff);
    run_op(MD_DIV, 32'h80000000, 32'hffffffff);
    check("div_ovf_const", {b32.hi, b32.lo}, 64'h00000000_80000000);
    mt(MD_MTLO, 32'h5);
    mt(MD_MTHI, 32'h0);
    run_op(MD_MADD, 32'h3, 32'h4);
    check("madd_const", {b32.hi, b32.lo}, 64'h00000000_00000011);
    run_op(MD_MSUBU, 32'h12, 32'h1);
    check("msubu_const", {b32.hi, b32.lo}, 64'hffffffff_ffffffff);
    prior = m_hilo;
    b32.start = 1'b1;
    b32.op = MD_DIV;
    b32.a = 32'd100;
    b32.b = 32'd7;
    step;
    b32.start = 1'b0;
    step;
    step;
    step;
    b32.cancel = 1'b1;
    step;
    b32.cancel = 1'b0;
    check("cancel_busy", 64'(b32.busy), 64'd0);
    check("cancel_hilo", {b32.hi, b32.lo}, prior);
    exp = model(MD_MULT, 32'd3, 32'd5, m_hilo);
    b32.start = 1'b1;
    b32.op = MD_MULT;
    b32.a = 32'd3;
    b32.b = 32'd5;
    step;
    b32.op = MD_DIV;
    b32.a = 32'd9;
    b32.b = 32'd2;
    step;
    b32.start = 1'b0;
    step;
    step;
    step;
    check("ignored_start_busy", 64'(b32.busy), 64'd1);
    step;
    check("ignored_start_done", 64'(b32.busy), 64'd0);
    check("ignored_start_hilo", {b32.hi, b32.lo}, exp);
    m_hilo = exp;
    b32.we = 1'b1;
    b32.start = 1'b1;
    b32.op = MD_MTLO;
    b32.a = 32'd77;
    step;
    b32.we = 1'b0;
    b32.start = 1'b0;
    m_hilo[31:0] = 32'd77;
    check("we_start_busy", 64'(b32.busy), 64'd0);
    check("we_start_hilo", {b32.hi, b32.lo}, m_hilo);
    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r >= 8) mt(md_op_t'(4'(r)), $urandom);
      else run_op(md_op_t'(4'(r)), pick(), pick());
    end
    mt(MD_MTHI, 32'hdeadbeef);
    b32.start = 1'b1;
    b32.op = MD_DIV;
    b32.a = 32'd50;
    b32.b = 32'd3;
    step;
    b32.start = 1'b0;
    step;
    step;
    reset = 1'b1;
    #1;
    check("async_reset_busy", 64'(b32.busy), 64'd0);
    check("async_reset_hilo", {b32.hi, b32.lo}, 64'd0);
    step;
    reset = 1'b0;
    m_hilo = '0;
    step;
    check("post_reset_busy", 64'(b32.busy), 64'd0);
    run_op(MD_MADDU, 32'hffffffff, 32'hffffffff);
    b16.start = 1'b1;
    b16.op = MD_MULT;
    b16.a = 16'hffff;
    b16.b = 16'h2;
    step;
    b16.start = 1'b0;
    check("w16_busy", 64'(b16.busy), 64'd1);
    step;
    check("w16_done", 64'(b16.busy), 64'd0);
    check("w16_mult", 64'({b16.hi, b16.lo}), 64'h00000000_fffffffe);
    b16.start = 1'b1;
    b16.op = MD_MULTU;
    step;
    b16.start = 1'b0;
    step;
    check("w16_multu", 64'({b16.hi, b16.lo}), 64'h00000000_0001fffe);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
